// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_RESP
  } state_e;

  // Tags are stored zero-extended to a fixed width so the entry type is geometry-independent.
  localparam int MAX_TAG_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
  } tag_entry_t;

  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_w);
    return addr_w - idx_w(sets) - off_w(line_w);
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Tree pseudo-LRU state per set: combinational victim lookup, registered update on access.
module icache_plru
  import icache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 4,
  localparam int IDX_W = idx_w(SETS),
  localparam int WAY_W = way_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_set,
  input  logic [WAY_W-1:0] upd_way,
  input  logic [IDX_W-1:0] vic_set,
  output logic [WAY_W-1:0] victim
);

  generate
    if (WAYS == 1) begin : g_dm
      assign victim = '0;
      logic unused_plru;
      assign unused_plru = ^{clk, rst, upd_en, upd_set, upd_way, vic_set};
    end else begin : g_tree
      localparam int LVL   = $clog2(WAYS);
      localparam int NODES = WAYS - 1;

      // Heap-ordered tree: node n lives at bit n-1; a bit value names the child to evict next.
      logic [NODES-1:0] tree_reg [SETS];
      logic [NODES-1:0] tree_vic;
      logic [NODES-1:0] tree_cur;
      logic [NODES-1:0] tree_next;
      logic [WAYS-1:0]  vic_oh;

      assign tree_vic = tree_reg[vic_set];
      assign tree_cur = tree_reg[upd_set];

      for (genvar gi = 0; gi < WAYS; gi++) begin : g_vic
        logic [LVL-1:0] match;
        for (genvar gl = 0; gl < LVL; gl++) begin : g_lvl
          localparam int   NODE = (1 << gl) + (gi >> (LVL - gl));
          localparam logic DIR  = 1'((gi >> (LVL - 1 - gl)) & 1);
          assign match[gl] = (tree_vic[NODE-1] == DIR);
        end
        assign vic_oh[gi] = &match;
      end

      always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
          if (vic_oh[w]) victim = WAY_W'(w);
        end
      end

      // Every node on the accessed way's path is pointed away from that way.
      for (genvar gl = 0; gl < LVL; gl++) begin : g_upd_lvl
        for (genvar gn = 0; gn < (1 << gl); gn++) begin : g_upd_node
          localparam int NODE = (1 << gl) + gn;
          logic on_path;
          assign on_path = ((upd_way >> (LVL - gl)) == WAY_W'(gn));
          assign tree_next[NODE-1] = on_path ? ~upd_way[LVL-1-gl] : tree_cur[NODE-1];
        end
      end

      for (genvar gi = 0; gi < SETS; gi++) begin : g_set
        always_ff @(posedge clk) begin
          if (rst) begin
            tree_reg[gi] <= '0;
          end else if (upd_en && (upd_set == IDX_W'(gi))) begin
            tree_reg[gi] <= tree_next;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with whole-line refill and tree pseudo-LRU replacement.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int SETS   = 4,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] core_inst_addr_i,
  input  logic              core_valid_req_i,
  output logic              Icache_ready_o,
  output logic [31:0]       Icache_inst_o,
  output logic              hit,
  output logic              pipe_stall,
  output logic [ADDR_W-1:0] Icache_addr_o,
  output logic              Icache_valid_req_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_data_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFF_W  = off_w(LINE_W);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_W);
  localparam int WORD_W = OFF_W - 2;
  localparam int WAY_W  = way_w(WAYS);

  state_e              state_reg, state_next;
  logic [ADDR_W-1:2]   addr_reg;
  logic [WAY_W-1:0]    victim_reg;
  logic                ready_reg, ready_next;
  logic                hit_reg, hit_next;
  logic [31:0]         inst_reg, inst_next;
  logic                stall_reg, stall_next;

  logic [IDX_W-1:0]    set_idx;
  logic [TAG_W-1:0]    tag_f;
  logic [WORD_W-1:0]   word_idx;

  tag_entry_t          tag_reg  [SETS][WAYS];
  logic [LINE_W-1:0]   data_reg [SETS][WAYS];

  logic [WAYS-1:0]     way_hit, way_inv;
  logic                hit_any, inv_any;
  logic [WAY_W-1:0]    hit_way, inv_way, plru_victim;
  logic                accept, refill_done, plru_upd;
  logic                unused_addr_lsb;

  assign set_idx  = addr_reg[OFF_W+IDX_W-1:OFF_W];
  assign tag_f    = addr_reg[ADDR_W-1:OFF_W+IDX_W];
  assign word_idx = addr_reg[OFF_W-1:2];
  assign unused_addr_lsb = ^core_inst_addr_i[1:0];

  function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line,
                                           input logic [WORD_W-1:0] idx);
    return line[{idx, 5'b0} +: 32];
  endfunction

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
      assign way_hit[gi] = tag_reg[set_idx][gi].valid &&
                           (tag_reg[set_idx][gi].tag == MAX_TAG_W'(tag_f));
      assign way_inv[gi] = !tag_reg[set_idx][gi].valid;
    end
  endgenerate

  // Descending scan so the lowest-numbered matching/invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (way_inv[w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  // A request seen while the previous response is still on the outputs is the old fetch being held.
  assign accept      = (state_reg == ST_IDLE) && core_valid_req_i && !ready_reg;
  assign refill_done = (state_reg == ST_REFILL) && mem_ready_i;
  assign plru_upd    = ((state_reg == ST_LOOKUP) && hit_any) || refill_done;

  icache_plru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk     (clk),
    .rst     (rst),
    .upd_en  (plru_upd),
    .upd_set (set_idx),
    .upd_way (refill_done ? victim_reg : hit_way),
    .vic_set (set_idx),
    .victim  (plru_victim)
  );

  always_comb begin
    state_next = state_reg;
    ready_next = 1'b0;
    hit_next   = 1'b0;
    inst_next  = inst_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit_any) begin
          ready_next = 1'b1;
          hit_next   = 1'b1;
          inst_next  = word_sel(data_reg[set_idx][hit_way], word_idx);
          state_next = ST_IDLE;
        end else begin
          state_next = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (mem_ready_i) begin
          ready_next = 1'b1;
          inst_next  = word_sel(mem_data_i, word_idx);
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    stall_next = (state_next == ST_LOOKUP) || (state_next == ST_REFILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      victim_reg <= '0;
      ready_reg  <= 1'b0;
      hit_reg    <= 1'b0;
      inst_reg   <= '0;
      stall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= ready_next;
      hit_reg   <= hit_next;
      inst_reg  <= inst_next;
      stall_reg <= stall_next;
      if (accept) addr_reg <= core_inst_addr_i[ADDR_W-1:2];
      if ((state_reg == ST_LOOKUP) && !hit_any) begin
        victim_reg <= inv_any ? inv_way : plru_victim;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
      for (genvar gj = 0; gj < WAYS; gj++) begin : g_way
        logic wr_en;
        assign wr_en = refill_done && (set_idx == IDX_W'(gi)) && (victim_reg == WAY_W'(gj));

        always_ff @(posedge clk) begin
          if (rst) begin
            tag_reg[gi][gj] <= '0;
          end else if (wr_en) begin
            tag_reg[gi][gj] <= '{valid: 1'b1, tag: MAX_TAG_W'(tag_f)};
          end
        end

        always_ff @(posedge clk) begin
          if (wr_en) data_reg[gi][gj] <= mem_data_i;
        end
      end
    end
  endgenerate

  assign Icache_ready_o     = ready_reg;
  assign hit                = hit_reg;
  assign Icache_inst_o      = inst_reg;
  assign pipe_stall         = stall_reg;
  assign Icache_valid_req_o = (state_reg == ST_REFILL);
  assign Icache_addr_o      = (state_reg == ST_REFILL) ?
                              {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (state_reg == ST_LOOKUP) begin
      if (hit_any) begin
        if (hit_cnt_reg != 32'hFFFF_FFFF) hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end else begin
        if (miss_cnt_reg != 32'hFFFF_FFFF) miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_reg;
  assign miss_cnt_o = miss_cnt_reg;
`endif

endmodule
